// File: rtl/key_debounce_pulse_if.sv
// Push-button conditioning bus: the raw pin going in, the cleaned
// level, event pulses and press counter coming out.
interface key_debounce_pulse_if;
  logic       key_in;
  logic       key_level;
  logic       key_press;
  logic       key_release;
  logic       key_long;
  logic [7:0] press_cnt;

  // Producer of the raw pin / consumer of the clean events.
  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long,
    input  press_cnt
  );

  // The debouncer itself.
  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_long,
    output press_cnt
  );
endinterface

// File: rtl/key_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, press/release debounce
// filter, one-cycle press/release/long-press events, a debounced level
// and an 8-bit wrapping press counter. Every output is registered.
module key_debounce_pulse #(
  parameter logic [31:0] DEBOUNCE_CYC = 32'd2_000_000,
  parameter logic [31:0] LONG_CYC     = 32'd100_000_000
) (
  input logic                  clk,
  input logic                  rst,
  key_debounce_pulse_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_FILT = 2'd3
  } state_t;

  // Terminal counts: a filter completes when deb_cnt reaches DEB_LAST,
  // and hold_cnt parks at LONG_LAST once the long-press point is reached.
  localparam logic [31:0] DEB_LAST  = DEBOUNCE_CYC - 32'd1;
  localparam logic [31:0] LONG_LAST = LONG_CYC - 32'd1;

  logic        s1;
  logic        key_s;

  state_t      state,     state_d;
  logic [31:0] deb_cnt,   deb_cnt_d;
  logic [31:0] hold_cnt,  hold_cnt_d;
  logic        long_done, long_done_d;
  logic        level,     level_d;
  logic        press,     press_d;
  logic        release_p, release_d;
  logic        long_p,    long_d;
  logic [7:0]  cnt,       cnt_d;

  // Two-flop synchroniser for the asynchronous pin; only key_s is used.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, giving a true shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1    <= 1'b0;
      key_s <= 1'b0;
    end else begin
      s1    <= bus.key_in;
      key_s <= s1;
    end
  end

  // State and output registers; reset is sampled on the clock edge.
  // NOTE: reset is synchronous here, so it only takes effect at a clk edge;
  // the synchroniser above is cleared too so no stale level leaks out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      hold_cnt  <= '0;
      long_done <= 1'b0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
      long_p    <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      deb_cnt   <= deb_cnt_d;
      hold_cnt  <= hold_cnt_d;
      long_done <= long_done_d;
      level     <= level_d;
      press     <= press_d;
      release_p <= release_d;
      long_p    <= long_d;
      cnt       <= cnt_d;
    end
  end

  // Next-state and next-output logic for the debounce FSM.
  // NOTE: every signal gets a default before the case statement, so no path
  // leaves one unassigned and no latch is inferred; pulses default to 0.
  always_comb begin
    state_d     = state;
    deb_cnt_d   = deb_cnt;
    hold_cnt_d  = hold_cnt;
    long_done_d = long_done;
    level_d     = level;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
    cnt_d       = cnt;

    // The hold timer and long-press rule run while the key is considered
    // down, including while a release is still being filtered, so a
    // release glitch does not restart the long-press measurement.
    if (state == HELD || state == RELEASE_FILT) begin
      if (hold_cnt < LONG_LAST) begin
        hold_cnt_d = hold_cnt + 32'd1;
      end
      if (hold_cnt == LONG_LAST && !long_done) begin
        long_d      = 1'b1;
        long_done_d = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        if (key_s) begin
          state_d   = PRESS_FILT;
          deb_cnt_d = '0;
        end
      end

      PRESS_FILT: begin
        if (!key_s) begin
          // Bounce: the high level did not last long enough.
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_d     = HELD;
          level_d     = 1'b1;
          press_d     = 1'b1;
          cnt_d       = cnt + 8'd1;
          hold_cnt_d  = '0;
          long_done_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt + 32'd1;
        end
      end

      HELD: begin
        if (!key_s) begin
          state_d   = RELEASE_FILT;
          deb_cnt_d = '0;
        end
      end

      RELEASE_FILT: begin
        if (key_s) begin
          // Glitch low while held: stay pressed, no new press event.
          state_d = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          deb_cnt_d = deb_cnt + 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.key_level   = level;
  assign bus.key_press   = press;
  assign bus.key_release = release_p;
  assign bus.key_long    = long_p;
  assign bus.press_cnt   = cnt;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Directed bench for key_debounce_pulse with DEBOUNCE_CYC=4, LONG_CYC=20.
// Inputs change 1 ns after a rising edge; outputs are read at that point,
// i.e. they reflect the edge just taken.
module tb_key_debounce_pulse;

  logic clk;
  logic rst;

  key_debounce_pulse_if bus ();

  key_debounce_pulse #(
    .DEBOUNCE_CYC(32'd4),
    .LONG_CYC    (32'd20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All outputs packed: {level, press, release, long, press_cnt}.
  function automatic logic [11:0] outs();
    return {bus.key_level, bus.key_press, bus.key_release, bus.key_long,
            bus.press_cnt};
  endfunction

  // Passive event monitor, sampled on the falling edge.
  int   cyc = 0;
  int   n_press = 0, n_release = 0, n_long = 0;
  int   n_coincide = 0, n_cnt_glitch = 0;
  int   last_press_cyc = 0, last_long_cyc = 0;
  logic rst_q = 1'b0;
  logic [7:0] cnt_prev = 8'd0;

  always @(posedge clk) begin
    cyc++;
    rst_q = rst;
  end

  always @(negedge clk) begin
    if (bus.key_press === 1'b1) begin
      n_press++;
      last_press_cyc = cyc;
    end
    if (bus.key_release === 1'b1) n_release++;
    if (bus.key_long === 1'b1) begin
      n_long++;
      last_long_cyc = cyc;
    end
    if (bus.key_press === 1'b1 && bus.key_release === 1'b1) n_coincide++;
    if (rst_q === 1'b1 && bus.press_cnt !== cnt_prev && bus.key_press !== 1'b1)
      n_cnt_glitch++;
    cnt_prev = bus.press_cnt;
  end

  // One clean press/release, long enough for both filters, short of a long press.
  task automatic press_release();
    bus.key_in = 1'b1;
    repeat (8) tick();
    bus.key_in = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int p0, r0, l0;

  initial begin
    rst        = 1'b0;
    bus.key_in = 1'b0;

    // Reset: all outputs zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_outs", 32'(outs()), 32'd0);
    end
    rst = 1'b1;
    repeat (5) tick();

    // Clean press: key_press at E0+6.
    bus.key_in = 1'b1;
    tick();                                   // E0
    repeat (5) tick();
    check("press_early", 32'(bus.key_press), 32'd0);
    check("level_early", 32'(bus.key_level), 32'd0);
    tick();                                   // E0+6
    check("press_pulse", 32'(bus.key_press), 32'd1);
    check("press_level", 32'(bus.key_level), 32'd1);
    check("press_cnt1",  32'(bus.press_cnt), 32'd1);
    tick();
    check("press_one_cycle", 32'(bus.key_press), 32'd0);
    check("level_holds", 32'(bus.key_level), 32'd1);

    // Short press release: key_release at E1+6.
    repeat (3) tick();
    bus.key_in = 1'b0;
    tick();                                   // E1
    repeat (5) tick();
    check("release_early", 32'(bus.key_release), 32'd0);
    check("release_level_early", 32'(bus.key_level), 32'd1);
    tick();                                   // E1+6
    check("release_pulse", 32'(bus.key_release), 32'd1);
    check("release_level", 32'(bus.key_level), 32'd0);
    tick();
    check("release_one_cycle", 32'(bus.key_release), 32'd0);
    check("short_no_long", 32'(n_long), 32'd0);

    // Bounce rejection: 1,1,0 repeating never gives 4 stable cycles.
    repeat (4) tick();
    p0 = n_press;
    for (int i = 0; i < 30; i++) begin
      bus.key_in = (i % 3 == 2) ? 1'b0 : 1'b1;
      tick();
      if (i % 6 == 5) check("bounce_level", 32'(bus.key_level), 32'd0);
    end
    bus.key_in = 1'b0;
    repeat (6) tick();
    check("bounce_no_press", 32'(n_press - p0), 32'd0);
    check("bounce_cnt", 32'(bus.press_cnt), 32'd1);

    // Long press completes on the same edge as release filtering.
    // Press at E0+6, long at E0+26; release low from E0+20 -> release at E0+26.
    bus.key_in = 1'b1;
    repeat (20) tick();                       // E0 .. E0+19
    bus.key_in = 1'b0;
    tick();                                   // E0+20
    repeat (5) tick();
    check("simul_long_early", 32'(bus.key_long), 32'd0);
    check("simul_rel_early", 32'(bus.key_release), 32'd0);
    tick();                                   // E0+26
    check("simul_long", 32'(bus.key_long), 32'd1);
    check("simul_release", 32'(bus.key_release), 32'd1);
    check("simul_level", 32'(bus.key_level), 32'd0);
    repeat (4) tick();

    // Long press with a 2-cycle release glitch.
    p0 = n_press; r0 = n_release; l0 = n_long;
    for (int i = 0; i < 30; i++) begin
      bus.key_in = (i == 12 || i == 13) ? 1'b0 : 1'b1;
      tick();
    end
    check("glitch_press_once", 32'(n_press - p0), 32'd1);
    check("glitch_no_release", 32'(n_release - r0), 32'd0);
    check("glitch_long_once", 32'(n_long - l0), 32'd1);
    check("glitch_long_delay", 32'(last_long_cyc - last_press_cyc), 32'd20);
    check("glitch_level", 32'(bus.key_level), 32'd1);
    check("glitch_cnt", 32'(bus.press_cnt), 32'd3);
    bus.key_in = 1'b0;
    repeat (8) tick();
    check("glitch_release", 32'(n_release - r0), 32'd1);
    check("glitch_level_off", 32'(bus.key_level), 32'd0);
    check("glitch_long_final", 32'(n_long - l0), 32'd1);

    // Counter wrap from a clean reset.
    rst = 1'b0;
    tick();
    check("wrap_reset_cnt", 32'(bus.press_cnt), 32'd0);
    rst = 1'b1;
    tick();
    p0 = n_press;
    repeat (255) press_release();
    check("wrap_255", 32'(bus.press_cnt), 32'd255);
    press_release();
    check("wrap_256", 32'(bus.press_cnt), 32'd0);
    press_release();
    check("wrap_257", 32'(bus.press_cnt), 32'd1);
    check("wrap_pulses", 32'(n_press - p0), 32'd257);

    // Reset while in PRESS_FILT.
    bus.key_in = 1'b1;
    tick();                                   // E0
    repeat (3) tick();                        // filtering
    p0 = n_press; r0 = n_release; l0 = n_long;
    rst = 1'b0;
    tick();
    check("rst_pf_outs", 32'(outs()), 32'd0);
    rst = 1'b1;
    tick();                                   // R1
    repeat (5) tick();
    check("rst_pf_no_press", 32'(n_press - p0), 32'd0);
    tick();                                   // R1+6
    check("rst_pf_repress", 32'(bus.key_press), 32'd1);
    check("rst_pf_cnt", 32'(bus.press_cnt), 32'd1);

    // Reset while HELD.
    repeat (3) tick();
    p0 = n_press; r0 = n_release; l0 = n_long;
    rst = 1'b0;
    tick();
    check("rst_held_outs", 32'(outs()), 32'd0);
    rst = 1'b1;
    tick();                                   // R1
    repeat (5) tick();
    check("rst_held_no_pulse", 32'(n_press - p0 + n_release - r0 + n_long - l0),
          32'd0);
    tick();                                   // R1+6
    check("rst_held_repress", 32'(bus.key_press), 32'd1);
    check("rst_held_cnt", 32'(bus.press_cnt), 32'd1);
    bus.key_in = 1'b0;
    repeat (10) tick();

    check("never_coincide", 32'(n_coincide), 32'd0);
    check("cnt_only_on_press", 32'(n_cnt_glitch), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
